gmii_flow_switch: RTL and testbench
===================================

Name: gmii_flow_switch

Overview:
- Four-port GMII cut-through forwarding core for the NetFPGA OpenFlow datapath.
- Ports 0–2 are data ports. Port 3 is the command port that programs an 8-entry destination-MAC forwarding table.
- Frames are forwarded with a fixed 16-cycle latency. There is no packet buffering; a frame that cannot get its egress port is dropped on that port.

Parameters:
- PIPE_DEPTH, 16, delay-line length in cycles from rxd/rx_dv to txd/tx_en.
- TBL_ENTRIES, 8, number of forwarding-table entries.
- CMD_ETYPE, 16'h88B5, EtherType that marks command frames on port 3.

Ports:
- sys_clk in 1: single clock; all GMII rx/tx signals are synchronous to it.
- sys_rst in 1: synchronous, active-high reset.
- gmii_N_rxd in 8 (N=0..3): receive data.
- gmii_N_rx_dv in 1 (N=0..3): receive data valid.
- gmii_N_txd out 8 (N=0..3): transmit data.
- gmii_N_tx_en out 1 (N=0..3): transmit enable.

Behaviour:
- Reset:
  - All txd=8'h00, all tx_en=0.
  - Table entries invalid; delay lines cleared; grants released; parsers idle.
- Ingress parser (per port, all four ports):
  - States: IDLE → PRE on rx_dv rising.
  - PRE → DA on byte 8'hD5 (SFD). If no SFD within 15 bytes, go to DROP.
  - DA counts 6 destination-MAC bytes, then goes to DECIDED (ports 0–2) or CMD (port 3).
  - Any state → IDLE when rx_dv=0. A frame ending before its 6th DA byte is discarded and never transmitted.
- Lookup (ports 0–2), in the cycle after the 6th DA byte:
  - DA=ff:ff:ff:ff:ff:ff → mask = all data ports except ingress.
  - Valid table hit (lowest matching index wins) → entry mask[2:0] with the ingress bit cleared.
  - Miss → flood to ports 0–2 except ingress.
  - mask[3] is ignored; port 3 never transmits (gmii_3_tx_en held 0, gmii_3_txd held 0).
- Egress grant:
  - At the decision cycle, each masked egress port is granted if idle. If several ingresses decide in the same cycle for the same egress, the lowest ingress number wins.
  - Busy or lost egress ports are excluded for the whole frame. There is no mid-frame grant.
  - A grant is held until the delayed rx_dv of the owner falls; the port is idle the following cycle. No IFG insertion (the source IFG is preserved).
- Datapath:
  - Each ingress has a PIPE_DEPTH-stage {dv,rxd} delay line.
  - Egress txd/tx_en = registered output of the granted ingress's delay line, so preamble and SFD are forwarded unchanged.
  - Ungranted egress: tx_en=0, txd=0.
  - Total latency is rx → tx = PIPE_DEPTH cycles exactly.
- Command frames (port 3), bytes after SFD: DA(6) SA(6) EtherType(2) opcode(1) index(1) MAC(6) mask(1).
  - Frame is ignored if EtherType ≠ CMD_ETYPE.
  - Opcode 8'h01: write entry index[2:0] = {valid=1, MAC, mask[3:0]}.
  - Opcode 8'h02: invalidate all entries.
  - Opcode 8'h03: invalidate entry index[2:0].
  - Other opcodes: ignored.
  - The command executes once the mask byte is received. If rx_dv drops before the mask byte, nothing is changed; FCS is not checked.
  - A table write takes effect for lookups starting the cycle after execution. A lookup in the same cycle sees the old contents.
- Reset asserted mid-frame: outputs drop to 0 next cycle. The in-progress frame is discarded; the next frame is parsed from its preamble.

Test Plan:
- Reset released, port 0 sends a 64-byte frame with DA 00:11:22:33:44:55 and an empty table → identical byte stream on gmii_1 and gmii_2 exactly 16 cycles later, tx_en high for 72 cycles; gmii_0 and gmii_3 stay 0.
- Port 3 command {opcode 01, index 2, MAC 00:11:22:33:44:55, mask 8'h04}, then the same frame on port 0 → output only on gmii_2; gmii_1 tx_en stays 0.
- Five back-to-back pings on port 0 to five hosts, entries programmed for three of them → hits go to the programmed port only, misses flood ports 1 and 2. Check counts per port.
- Ports 0 and 1 start broadcast frames in the same cycle → port 0 wins gmii_2; port 1's frame is absent on gmii_2; gmii_0 carries port 1's frame and gmii_1 carries port 0's frame.
- Frame on port 1 truncated after 4 DA bytes; and a port 3 frame with EtherType 0x0800 → no tx_en on any port; table unchanged.
- Opcode 02 on port 3, then a frame to a previously programmed MAC → flooded to both other data ports.

Source files
------------

// File: rtl/gmii_flow_switch.sv
// gmii_flow_switch: four-port GMII cut-through forwarding core.
//
// Ports 0-2 are data ports. Each has a parser that finds the SFD and
// collects the destination MAC. In the cycle after the sixth DA byte,
// the lookup forms an egress mask and the grant logic claims the idle
// egress ports. The frame then leaves through a fixed delay line, so
// forwarding latency is exactly PIPE_DEPTH cycles.
//
// Port 3 is receive-only. It carries command frames that program the
// forwarding table. gmii_3_txd and gmii_3_tx_en are held at 0.
//
// Ports:
//   sys_clk, sys_rst          single clock; synchronous active-high reset
//   gmii_N_rxd / gmii_N_rx_dv receive byte and data valid, N = 0..3
//   gmii_N_txd / gmii_N_tx_en transmit byte and enable, N = 0..3
module gmii_flow_switch #(
  parameter int          PIPE_DEPTH  = 16,
  parameter int          TBL_ENTRIES = 8,
  parameter logic [15:0] CMD_ETYPE   = 16'h88B5
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] gmii_0_rxd,
  input  logic       gmii_0_rx_dv,
  input  logic [7:0] gmii_1_rxd,
  input  logic       gmii_1_rx_dv,
  input  logic [7:0] gmii_2_rxd,
  input  logic       gmii_2_rx_dv,
  input  logic [7:0] gmii_3_rxd,
  input  logic       gmii_3_rx_dv,
  output logic [7:0] gmii_0_txd,
  output logic       gmii_0_tx_en,
  output logic [7:0] gmii_1_txd,
  output logic       gmii_1_tx_en,
  output logic [7:0] gmii_2_txd,
  output logic       gmii_2_tx_en,
  output logic [7:0] gmii_3_txd,
  output logic       gmii_3_tx_en
);
  localparam int IW = $clog2(TBL_ENTRIES);
  // The egress register is the last of the PIPE_DEPTH stages.
  localparam int DL = PIPE_DEPTH - 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DA, S_DECIDED, S_CMD, S_DROP} parse_state_e;

  logic [3:0][7:0] rxd;
  logic [3:0]      rx_dv;
  assign rxd   = {gmii_3_rxd, gmii_2_rxd, gmii_1_rxd, gmii_0_rxd};
  assign rx_dv = {gmii_3_rx_dv, gmii_2_rx_dv, gmii_1_rx_dv, gmii_0_rx_dv};

  parse_state_e state_q [4];
  parse_state_e state_d [4];
  logic [4:0]   cnt_q [4];
  logic [4:0]   cnt_d [4];
  logic [3:0]   dv_prev_q;

  logic [2:0][47:0] da_q, da_d;
  logic [2:0]       decide_q, decide_d;

  logic [15:0]   cmd_etype_q, cmd_etype_d;
  logic [7:0]    cmd_op_q, cmd_op_d;
  logic [IW-1:0] cmd_idx_q, cmd_idx_d;
  logic [47:0]   cmd_mac_q, cmd_mac_d;
  logic          cmd_exec;

  // mask[3] has no effect because port 3 never transmits, so only bits [2:0] are kept.
  logic [TBL_ENTRIES-1:0]       tbl_valid_q, tbl_valid_d;
  logic [TBL_ENTRIES-1:0][47:0] tbl_mac_q, tbl_mac_d;
  logic [TBL_ENTRIES-1:0][2:0]  tbl_mask_q, tbl_mask_d;

  logic [2:0][DL-1:0][8:0] dl_q, dl_d;
  logic [2:0][2:0]         fwd_mask;
  logic [2:0]              gnt_q, gnt_d, started_q, started_d;
  logic [2:0][1:0]         own_q, own_d;
  logic [2:0][8:0]         tx_q, tx_d;

  // Ingress parsers. A new frame is recognised only on a rising rx_dv.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      if (!rx_dv[p]) begin
        state_d[p] = S_IDLE;
        cnt_d[p]   = '0;
      end else begin
        case (state_q[p])
          S_IDLE: if (!dv_prev_q[p]) begin
            state_d[p] = S_PRE;
            cnt_d[p]   = 5'd1;
          end
          S_PRE: begin
            if (rxd[p] == 8'hD5) begin
              state_d[p] = S_DA;
              cnt_d[p]   = '0;
            end else if (cnt_q[p] >= 5'd14) begin
              state_d[p] = S_DROP;
            end else begin
              cnt_d[p] = cnt_q[p] + 5'd1;
            end
          end
          S_DA: begin
            cnt_d[p] = cnt_q[p] + 5'd1;
            if (cnt_q[p] == 5'd5) state_d[p] = (p == 3) ? S_CMD : S_DECIDED;
          end
          S_CMD: begin
            cnt_d[p] = cnt_q[p] + 5'd1;
            if (cnt_q[p] == 5'd22) state_d[p] = S_DROP;
          end
          default: ;
        endcase
      end
    end
  end

  // DA capture. decide_q pulses in the cycle after the sixth DA byte.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      da_d[i]     = da_q[i];
      decide_d[i] = 1'b0;
      if (rx_dv[i] && state_q[i] == S_DA) begin
        da_d[i]     = {da_q[i][39:0], rxd[i]};
        decide_d[i] = (cnt_q[i] == 5'd5);
      end
    end
  end

  // Command fields, counted in bytes after the SFD. The mask byte is
  // used directly from rxd in its own cycle.
  always_comb begin
    cmd_etype_d = cmd_etype_q;
    cmd_op_d    = cmd_op_q;
    cmd_idx_d   = cmd_idx_q;
    cmd_mac_d   = cmd_mac_q;
    cmd_exec    = 1'b0;
    if (rx_dv[3] && state_q[3] == S_CMD) begin
      case (cnt_q[3])
        5'd12: cmd_etype_d[15:8] = rxd[3];
        5'd13: cmd_etype_d[7:0]  = rxd[3];
        5'd14: cmd_op_d          = rxd[3];
        5'd15: cmd_idx_d         = rxd[3][IW-1:0];
        5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21: cmd_mac_d = {cmd_mac_q[39:0], rxd[3]};
        5'd22: cmd_exec          = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    tbl_valid_d = tbl_valid_q;
    tbl_mac_d   = tbl_mac_q;
    tbl_mask_d  = tbl_mask_q;
    if (cmd_exec && cmd_etype_q == CMD_ETYPE) begin
      case (cmd_op_q)
        8'h01: begin
          tbl_valid_d[cmd_idx_q] = 1'b1;
          tbl_mac_d[cmd_idx_q]   = cmd_mac_q;
          tbl_mask_d[cmd_idx_q]  = rxd[3][2:0];
        end
        8'h02: tbl_valid_d = '0;
        8'h03: tbl_valid_d[cmd_idx_q] = 1'b0;
        default: ;
      endcase
    end
  end

  // Lookup reads the registered table, so a write in the same cycle is not seen.
  // The scan runs from the highest index down so the lowest matching index wins.
  always_comb begin
    logic [2:0] lk_mask;
    for (int i = 0; i < 3; i++) begin
      lk_mask = 3'b111;
      for (int e = TBL_ENTRIES - 1; e >= 0; e--) begin
        if (tbl_valid_q[e] && tbl_mac_q[e] == da_q[i]) lk_mask = tbl_mask_q[e];
      end
      if (&da_q[i]) lk_mask = 3'b111;
      fwd_mask[i] = lk_mask & ~(3'b001 << i);
    end
  end

  // Egress grant. An idle egress is claimed at the decision cycle, and the
  // lowest-numbered ingress wins a tie. The grant is released after the
  // owner's delayed rx_dv has been seen high and then falls.
  always_comb begin
    for (int e = 0; e < 3; e++) begin
      gnt_d[e]     = gnt_q[e];
      own_d[e]     = own_q[e];
      started_d[e] = started_q[e];
      if (gnt_q[e]) begin
        if (dl_q[own_q[e]][DL-1][8]) begin
          started_d[e] = 1'b1;
        end else if (started_q[e]) begin
          gnt_d[e]     = 1'b0;
          started_d[e] = 1'b0;
        end
      end else begin
        for (int i = 2; i >= 0; i--) begin
          if (decide_q[i] && fwd_mask[i][e]) begin
            gnt_d[e] = 1'b1;
            own_d[e] = 2'(i);
          end
        end
      end
      tx_d[e] = gnt_q[e] ? dl_q[own_q[e]][DL-1] : 9'h000;
    end
  end

  // Delay lines store zero data while rx_dv is low, so idle txd stays 0.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dl_d[i] = {dl_q[i][DL-2:0], (rx_dv[i] ? {1'b1, rxd[i]} : 9'h000)};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int p = 0; p < 4; p++) begin
        state_q[p] <= S_IDLE;
        cnt_q[p]   <= '0;
      end
      // Set to 1 so a frame already in flight at reset release is not parsed mid-stream.
      dv_prev_q   <= '1;
      da_q        <= '0;
      decide_q    <= '0;
      cmd_etype_q <= '0;
      cmd_op_q    <= '0;
      cmd_idx_q   <= '0;
      cmd_mac_q   <= '0;
      tbl_valid_q <= '0;
      tbl_mac_q   <= '0;
      tbl_mask_q  <= '0;
      dl_q        <= '0;
      gnt_q       <= '0;
      started_q   <= '0;
      own_q       <= '0;
      tx_q        <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
      dv_prev_q   <= rx_dv;
      da_q        <= da_d;
      decide_q    <= decide_d;
      cmd_etype_q <= cmd_etype_d;
      cmd_op_q    <= cmd_op_d;
      cmd_idx_q   <= cmd_idx_d;
      cmd_mac_q   <= cmd_mac_d;
      tbl_valid_q <= tbl_valid_d;
      tbl_mac_q   <= tbl_mac_d;
      tbl_mask_q  <= tbl_mask_d;
      dl_q        <= dl_d;
      gnt_q       <= gnt_d;
      started_q   <= started_d;
      own_q       <= own_d;
      tx_q        <= tx_d;
    end
  end

  assign gmii_0_txd   = tx_q[0][7:0];
  assign gmii_0_tx_en = tx_q[0][8];
  assign gmii_1_txd   = tx_q[1][7:0];
  assign gmii_1_tx_en = tx_q[1][8];
  assign gmii_2_txd   = tx_q[2][7:0];
  assign gmii_2_tx_en = tx_q[2][8];
  assign gmii_3_txd   = 8'h00;
  assign gmii_3_tx_en = 1'b0;
endmodule

// File: tb/tb_gmii_flow_switch.sv
// Testbench for gmii_flow_switch. Each scenario is a set of frames placed
// at start cycles, and each frame carries its expected egress port mask.
// Every egress stream is compared cycle by cycle against the ingress bytes
// shifted by 16 cycles.
module tb_gmii_flow_switch;
  localparam int MAXC = 1000;
  localparam logic [47:0] H1  = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BC  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] CDA = 48'h0A_00_00_00_00_03;
  localparam int NV = 20;

  typedef struct {
    int          port;
    logic [47:0] da;
    logic [15:0] etype;
    logic [7:0]  op;
    logic [7:0]  idx;
    logic [47:0] mac;
    logic [7:0]  mbyte;
    int          len;    // bytes after the SFD
    logic [3:0]  emask;  // expected egress ports
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [3:0][7:0] rxd, txd;
  logic [3:0]      rx_dv, tx_en;

  gmii_flow_switch dut (
    .sys_clk(clk), .sys_rst(rst),
    .gmii_0_rxd(rxd[0]), .gmii_0_rx_dv(rx_dv[0]),
    .gmii_1_rxd(rxd[1]), .gmii_1_rx_dv(rx_dv[1]),
    .gmii_2_rxd(rxd[2]), .gmii_2_rx_dv(rx_dv[2]),
    .gmii_3_rxd(rxd[3]), .gmii_3_rx_dv(rx_dv[3]),
    .gmii_0_txd(txd[0]), .gmii_0_tx_en(tx_en[0]),
    .gmii_1_txd(txd[1]), .gmii_1_tx_en(tx_en[1]),
    .gmii_2_txd(txd[2]), .gmii_2_tx_en(tx_en[2]),
    .gmii_3_txd(txd[3]), .gmii_3_tx_en(tx_en[3])
  );

  logic [8:0] stim [4][MAXC];
  logic [8:0] expv [4][MAXC];
  logic [8:0] logv [4][MAXC];
  logic       rst_s [MAXC];
  int n_vec, n_miss;
  vec_t vecs [NV];

  function automatic vec_t mk(input int port, input logic [47:0] da, input logic [15:0] et,
                              input logic [7:0] op, input logic [7:0] idx, input logic [47:0] mac,
                              input logic [7:0] mb, input int len, input logic [3:0] em);
    vec_t v;
    v.port = port; v.da = da; v.etype = et; v.op = op; v.idx = idx;
    v.mac = mac; v.mbyte = mb; v.len = len; v.emask = em;
    return v;
  endfunction

  function automatic logic [7:0] frame_byte(input vec_t v, input int k);
    int j;
    logic [47:0] sa;
    j  = k - 8;
    sa = {40'h02_00_00_00_00, 8'(v.port)};
    if (k < 7) return 8'h55;
    if (k == 7) return 8'hD5;
    if (j < 6) return v.da[47-8*j -: 8];
    if (j < 12) return sa[47-8*(j-6) -: 8];
    if (j == 12) return v.etype[15:8];
    if (j == 13) return v.etype[7:0];
    if (j == 14) return v.op;
    if (j == 15) return v.idx;
    if (j < 22) return v.mac[47-8*(j-16) -: 8];
    if (j == 22) return v.mbyte;
    return 8'(j + 32 * v.port);
  endfunction

  // driver tasks
  task automatic clear_scn();
    for (int c = 0; c < MAXC; c++) begin
      rst_s[c] = 1'b0;
      for (int p = 0; p < 4; p++) begin
        stim[p][c] = '0; expv[p][c] = '0; logv[p][c] = '0;
      end
    end
  endtask

  task automatic add_frame(input vec_t v, input int start);
    for (int k = 0; k < 8 + v.len; k++) begin
      stim[v.port][start+k] = {1'b1, frame_byte(v, k)};
      for (int e = 0; e < 4; e++)
        if (v.emask[e]) expv[e][start+16+k] = {1'b1, frame_byte(v, k)};
    end
  endtask

  task automatic run_scn(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      rst = rst_s[c];
      for (int p = 0; p < 4; p++) begin
        rx_dv[p] = stim[p][c][8];
        rxd[p]   = stim[p][c][7:0];
      end
      @(negedge clk);
      for (int e = 0; e < 4; e++) logv[e][c] = {tx_en[e], txd[e]};
    end
  endtask

  // scoreboard
  task automatic check_scn(input int id, input int ncyc);
    int bad, first, en_got, en_exp;
    for (int e = 0; e < 4; e++) begin
      bad = 0; first = -1; en_got = 0; en_exp = 0;
      for (int c = 0; c < ncyc; c++) begin
        if (logv[e][c] !== expv[e][c]) begin
          bad++;
          if (first < 0) first = c;
        end
        en_got += int'(logv[e][c][8]);
        en_exp += int'(expv[e][c][8]);
      end
      n_vec++;
      if (bad != 0) begin
        n_miss++;
        $display("FAIL case%0d port%0d stream: %0d bad cycles, first at cycle %0d got %h want %h",
                 id, e, bad, first, logv[e][first], expv[e][first]);
      end
      n_vec++;
      if (en_got != en_exp) begin
        n_miss++;
        $display("FAIL case%0d port%0d tx_en cycles: got %0d want %0d", id, e, en_got, en_exp);
      end
    end
  endtask

  function automatic int frame_count(input int e, input int ncyc);
    int n;
    n = 0;
    for (int c = 1; c < ncyc; c++) if (logv[e][c][8] && !logv[e][c-1][8]) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc, got;
    n_vec = 0; n_miss = 0;
    rst = 1'b1; rx_dv = '0; rxd = '0;

    vecs[0]  = mk(0, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0110); // empty table: flood
    vecs[1]  = mk(3, CDA, 16'h88B5, 8'h01, 8'h02, H1,    8'h04, 64, 4'b0000); // idx2 -> port 2
    vecs[2]  = mk(0, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0100);
    vecs[3]  = mk(1, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 4,  4'b0000); // cut after 4 DA bytes
    vecs[4]  = mk(3, CDA, 16'h0800, 8'h01, 8'h02, H1,    8'h02, 64, 4'b0000); // wrong EtherType
    vecs[5]  = mk(0, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0100); // table unchanged
    vecs[6]  = mk(2, BC,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0011); // broadcast
    vecs[7]  = mk(1, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0100);
    vecs[8]  = mk(2, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0000); // hit points at ingress
    vecs[9]  = mk(1, 48'h00_11_22_33_44_56, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0101);
    vecs[10] = mk(3, CDA, 16'h88B5, 8'h01, 8'h04, H1,    8'h01, 64, 4'b0000); // duplicate at idx4
    vecs[11] = mk(1, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0100); // idx2 still wins
    vecs[12] = mk(3, CDA, 16'h88B5, 8'h03, 8'h02, 48'h0, 8'h00, 64, 4'b0000); // invalidate idx2
    vecs[13] = mk(1, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0001); // idx4 now hits
    vecs[14] = mk(3, CDA, 16'h88B5, 8'h02, 8'h00, 48'h0, 8'h00, 64, 4'b0000); // invalidate all
    vecs[15] = mk(0, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0110);
    vecs[16] = mk(3, CDA, 16'h88B5, 8'h07, 8'h03, H1,    8'h04, 64, 4'b0000); // unknown opcode
    vecs[17] = mk(0, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0110);
    vecs[18] = mk(3, CDA, 16'h88B5, 8'h01, 8'h03, H1,    8'h04, 22, 4'b0000); // ends before mask byte
    vecs[19] = mk(0, H1,  16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0110);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int e = 0; e < 4; e++) begin
      n_vec++;
      if ({tx_en[e], txd[e]} !== 9'h000) begin
        n_miss++;
        $display("FAIL reset port%0d: got %h want 000", e, {tx_en[e], txd[e]});
      end
    end

    for (int i = 0; i < NV; i++) begin
      clear_scn();
      add_frame(vecs[i], 2);
      nc = 2 + 8 + vecs[i].len + 24;
      run_scn(nc);
      check_scn(i, nc);
    end

    // Ports 0 and 1 broadcast in the same cycle. Port 0 wins egress 2.
    clear_scn();
    add_frame(mk(0, BC, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0110), 2);
    add_frame(mk(1, BC, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0001), 2);
    run_scn(98);
    check_scn(100, 98);

    // Port 1 decides while egress 2 is busy. Egress 2 stays excluded for the whole frame.
    clear_scn();
    add_frame(mk(0, BC, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0110), 2);
    add_frame(mk(1, BC, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0001), 10);
    run_scn(106);
    check_scn(101, 106);

    // Program three hosts, then send five back-to-back pings from port 0.
    clear_scn();
    add_frame(mk(3, CDA, 16'h88B5, 8'h02, 8'h00, 48'h0, 8'h00, 64, 4'b0000), 2);
    add_frame(mk(3, CDA, 16'h88B5, 8'h01, 8'h00, 48'hAA_00_00_00_00_01, 8'h02, 64, 4'b0000), 86);
    add_frame(mk(3, CDA, 16'h88B5, 8'h01, 8'h01, 48'hAA_00_00_00_00_02, 8'h0C, 64, 4'b0000), 170);
    add_frame(mk(3, CDA, 16'h88B5, 8'h01, 8'h05, 48'hAA_00_00_00_00_03, 8'h03, 64, 4'b0000), 254);
    add_frame(mk(0, 48'hAA_00_00_00_00_01, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0010), 340);
    add_frame(mk(0, 48'hBB_00_00_00_00_01, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0110), 424);
    add_frame(mk(0, 48'hAA_00_00_00_00_02, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0100), 508);
    add_frame(mk(0, 48'hBB_00_00_00_00_02, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0110), 592);
    add_frame(mk(0, 48'hAA_00_00_00_00_03, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0010), 676);
    run_scn(772);
    check_scn(102, 772);
    got = frame_count(1, 772);
    n_vec++;
    if (got != 4) begin
      n_miss++;
      $display("FAIL ping frames port1: got %0d want 4", got);
    end
    got = frame_count(2, 772);
    n_vec++;
    if (got != 3) begin
      n_miss++;
      $display("FAIL ping frames port2: got %0d want 3", got);
    end

    // Reset mid-frame: outputs drop the next cycle and the rest of the frame is
    // discarded. A later frame is forwarded normally.
    clear_scn();
    add_frame(mk(0, BC, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0110), 2);
    rst_s[30] = 1'b1;
    rst_s[31] = 1'b1;
    for (int c = 31; c < MAXC; c++)
      for (int e = 0; e < 4; e++) expv[e][c] = '0;
    add_frame(mk(0, BC, 16'h0800, 8'h00, 8'h00, 48'h0, 8'h00, 64, 4'b0110), 100);
    run_scn(196);
    check_scn(103, 196);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
